// File: rtl/change_dispenser.sv
// change_dispenser: pays out the change owed by vending_machine as greedy
// 2-cent / 1-cent coin requests. Each coin uses a four-phase req/ack handshake
// with the hoppers. A watchdog traps a silent or stuck hopper in a sticky FAULT.
module change_dispenser #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       d,
  input  logic [2:0] r,
  input  logic       ack,
  output logic       coin2,
  output logic       coin1,
  output logic       busy,
  output logic       done,
  output logic       fault
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT_LOW, DONE, FAULT} state_t;

  // The last cycle index allowed while waiting on ack before giving up.
  localparam logic [7:0] TMAX = 8'(ACK_TIMEOUT - 1);

  state_t     state;
  logic [2:0] bal;
  logic [7:0] tmr;

  // Payout FSM; every output is registered and updated together with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      bal   <= '0;
      tmr   <= '0;
      coin2 <= 1'b0;
      coin1 <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      fault <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // ack is ignored here. A zero amount still produces a done pulse.
          if (d) begin
            busy <= 1'b1;
            if (r != 3'd0) begin
              bal   <= r;
              tmr   <= '0;
              coin2 <= (r >= 3'd2);
              coin1 <= (r <  3'd2);
              state <= REQ;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        REQ: begin
          // The selected request stays fixed until the hopper acks.
          if (ack) begin
            bal   <= bal - (coin2 ? 3'd2 : 3'd1);
            coin2 <= 1'b0;
            coin1 <= 1'b0;
            tmr   <= '0;
            state <= WAIT_LOW;
          end else if (tmr == TMAX) begin
            coin2 <= 1'b0;
            coin1 <= 1'b0;
            fault <= 1'b1;
            state <= FAULT;
          end else begin
            tmr <= tmr + 8'd1;
          end
        end
        WAIT_LOW: begin
          // Wait for ack to release. Then finish, or pick the next coin greedily.
          if (!ack) begin
            if (bal == 3'd0) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              tmr   <= '0;
              coin2 <= (bal >= 3'd2);
              coin1 <= (bal <  3'd2);
              state <= REQ;
            end
          end else if (tmr == TMAX) begin
            fault <= 1'b1;
            state <= FAULT;
          end else begin
            tmr <= tmr + 8'd1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        FAULT: begin
          // Terminal state. Outputs were set on entry and only reset clears them.
          state <= FAULT;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser. It includes a hopper model that acks one
// cycle after a request and releases one cycle after the request drops.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       reset, d, ack;
  logic [2:0] r;
  logic       coin2, coin1, busy, done, fault;

  logic       hopper_en, man_ack;
  logic       hop_ack = 1'b0;
  logic       req_d   = 1'b0;

  int nassert = 0;
  int nfail   = 0;

  int   seq_q[$];
  int   done_cnt = 0;
  logic p2 = 1'b0;
  logic p1 = 1'b0;

  // Expected greedy payouts, one hex digit per coin (first coin is the high digit).
  int exp_seq [8] = '{'h0, 'h1, 'h2, 'h21, 'h22, 'h221, 'h222, 'h2221};
  int exp_n   [8] = '{0, 1, 1, 2, 2, 3, 3, 4};

  change_dispenser #(.ACK_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .d(d), .r(r), .ack(ack),
    .coin2(coin2), .coin1(coin1), .busy(busy), .done(done), .fault(fault)
  );

  always #5 clk = ~clk;

  assign ack = hopper_en ? hop_ack : man_ack;

  // Hopper model: ack trails the request by one cycle, and release trails the drop by one cycle.
  always @(posedge clk) begin
    #1;
    if (reset) begin
      hop_ack = 1'b0;
      req_d   = 1'b0;
    end else begin
      hop_ack = req_d;
      req_d   = coin1 | coin2;
    end
  end

  // Monitor: record each coin request rising edge and count done pulses.
  always @(negedge clk) begin
    if (coin2 && !p2) seq_q.push_back(2);
    if (coin1 && !p1) seq_q.push_back(1);
    if (done) done_cnt++;
    p2 = coin2;
    p1 = coin1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int packed_seq(input int from);
    int v = 0;
    for (int i = from; i < seq_q.size(); i++) v = v * 16 + seq_q[i];
    return v;
  endfunction

  task automatic start_d(input logic [2:0] rv);
    @(posedge clk); #1 d = 1'b1; r = rv;
    @(posedge clk); #1 d = 1'b0; r = 3'd0;
  endtask

  task automatic wait_done(output int bcyc, output bit seen);
    bcyc = 0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (busy) bcyc++;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; d = 1'b0; r = 3'd0; man_ack = 1'b0; hopper_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    nassert++;
    if ({coin2, coin1, busy, done, fault} !== 5'b0) begin
      nfail++; $display("FAIL reset_outputs: got %b expected 00000", {coin2, coin1, busy, done, fault});
    end
    nassert++;
    if ({dut.bal, dut.tmr} !== 11'd0) begin
      nfail++; $display("FAIL reset_state: got bal=%0d tmr=%0d expected 0 0", dut.bal, dut.tmr);
    end
    reset = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_payout(input logic [2:0] rv);
    int s, dc, bc;
    bit seen;
    s  = seq_q.size();
    dc = done_cnt;
    start_d(rv);
    wait_done(bc, seen);
    nassert++;
    if (!seen) begin
      nfail++; $display("FAIL payout_done_seen r=%0d: got none expected done pulse", rv);
    end
    nassert++;
    if (bc != 4 * exp_n[rv] + 1) begin
      nfail++; $display("FAIL payout_busy_cycles r=%0d: got %0d expected %0d", rv, bc, 4 * exp_n[rv] + 1);
    end
    @(negedge clk);
    nassert++;
    if (busy !== 1'b0) begin
      nfail++; $display("FAIL payout_busy_fall r=%0d: got %b expected 0", rv, busy);
    end
    repeat (3) @(negedge clk);
    nassert++;
    if (packed_seq(s) != exp_seq[rv] || seq_q.size() - s != exp_n[rv]) begin
      nfail++; $display("FAIL payout_seq r=%0d: got %0h expected %0h", rv, packed_seq(s), exp_seq[rv]);
    end
    nassert++;
    if (done_cnt - dc != 1) begin
      nfail++; $display("FAIL payout_done_count r=%0d: got %0d expected 1", rv, done_cnt - dc);
    end
  endtask

  task automatic test_full_payout;
    test_payout(3'd7);
  endtask

  task automatic test_each_value;
    for (int v = 0; v < 7; v++) test_payout(3'(v));
  endtask

  task automatic test_d_while_busy;
    int s, dc, bc;
    bit seen;
    s  = seq_q.size();
    dc = done_cnt;
    start_d(3'd5);
    repeat (3) @(posedge clk);
    #1 d = 1'b1; r = 3'd5;
    @(posedge clk); #1 d = 1'b0; r = 3'd0;
    wait_done(bc, seen);
    repeat (20) @(negedge clk);
    nassert++;
    if (packed_seq(s) != 'h221 || seq_q.size() - s != 3) begin
      nfail++; $display("FAIL busy_ignore_seq: got %0h expected 221", packed_seq(s));
    end
    nassert++;
    if (done_cnt - dc != 1 || busy !== 1'b0) begin
      nfail++; $display("FAIL busy_ignore_done: got done=%0d busy=%b expected 1 0", done_cnt - dc, busy);
    end
  endtask

  task automatic test_timeout;
    int hi = 0;
    int s;
    hopper_en = 1'b0; man_ack = 1'b0;
    start_d(3'd3);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (coin2 && !fault) hi++;
    end
    nassert++;
    if (hi != 16) begin
      nfail++; $display("FAIL timeout_req_cycles: got %0d expected 16", hi);
    end
    @(negedge clk);
    nassert++;
    if ({fault, coin2, coin1, busy, done} !== 5'b10010) begin
      nfail++; $display("FAIL timeout_fault: got %b expected 10010", {fault, coin2, coin1, busy, done});
    end
    s = seq_q.size();
    start_d(3'd1);
    repeat (5) @(negedge clk);
    nassert++;
    if ({fault, coin2, coin1, busy} !== 4'b1001 || seq_q.size() != s) begin
      nfail++; $display("FAIL timeout_d_ignored: got %b expected 1001", {fault, coin2, coin1, busy});
    end
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    nassert++;
    if (fault !== 1'b0) begin
      nfail++; $display("FAIL timeout_reset_clear: got %b expected 0", fault);
    end
  endtask

  task automatic test_stuck_ack;
    int s, okc = 0;
    hopper_en = 1'b0; man_ack = 1'b0;
    s = seq_q.size();
    @(posedge clk); #1 d = 1'b1; r = 3'd4; man_ack = 1'b1;
    @(posedge clk); #1 d = 1'b0; r = 3'd0;
    @(negedge clk);
    nassert++;
    if (coin2 !== 1'b1) begin
      nfail++; $display("FAIL stuck_first_req: got %b expected 1", coin2);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (!fault && !coin2 && busy) okc++;
    end
    nassert++;
    if (okc != 16) begin
      nfail++; $display("FAIL stuck_wait_cycles: got %0d expected 16", okc);
    end
    @(negedge clk);
    nassert++;
    if ({fault, coin2, busy} !== 3'b101) begin
      nfail++; $display("FAIL stuck_fault: got %b expected 101", {fault, coin2, busy});
    end
    nassert++;
    if (seq_q.size() - s != 1 || packed_seq(s) != 'h2) begin
      nfail++; $display("FAIL stuck_coin_count: got %0d coins expected 1", seq_q.size() - s);
    end
    man_ack = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    hopper_en = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_mid_payout;
    int   cnt = 0;
    logic last = 1'b0;
    int   s, bc;
    bit   seen;
    hopper_en = 1'b1;
    start_d(3'd7);
    for (int i = 0; i < 100 && cnt < 2; i++) begin
      @(negedge clk);
      if (coin2 && !last) cnt++;
      last = coin2;
    end
    nassert++;
    if (cnt != 2) begin
      nfail++; $display("FAIL midreset_second_req: got %0d requests expected 2", cnt);
    end
    #1 reset = 1'b1;
    #1;
    nassert++;
    if ({coin2, coin1, busy, dut.bal} !== 6'd0) begin
      nfail++; $display("FAIL midreset_async: got coin2=%b busy=%b bal=%0d expected 0 0 0", coin2, busy, dut.bal);
    end
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    s = seq_q.size();
    start_d(3'd1);
    wait_done(bc, seen);
    repeat (3) @(negedge clk);
    nassert++;
    if (!seen || packed_seq(s) != 'h1 || seq_q.size() - s != 1) begin
      nfail++; $display("FAIL midreset_recover: got %0h expected 1", packed_seq(s));
    end
  endtask

  initial begin
    test_reset();
    test_full_payout();
    test_each_value();
    test_d_while_busy();
    test_timeout();
    test_stuck_ack();
    test_reset_mid_payout();
    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
